biquad_coeff_loader: RTL and testbench
======================================

// Module: biquad_coeff_loader
// PURPOSE
//  Writer side of the biquad pole-IIR coefficient port (coeff_dat/coeff_wr/coeff_update).
//  Host writes NCOEFF words into a staging file, then commits. The block shifts them serially
//  down the DSP B-cascade (B1 regs), then issues one update pulse (B1->B2) so all
//  coefficients switch in the same cycle. Sits in the IIR clock domain beside the pole-IIR.
// PARAMETERS
//  NCOEFF    4   coefficients per chain (one per DSP); >=2
//  DAT_BITS  18  coefficient width (DSP B port)
//  AW        2   staging address width, = clog2(NCOEFF)
// PORTS
//  clk             in   1         single clock
//  rst_n           in   1         asynchronous, active-low reset
//  cfg_wr_i        in   1         staging write strobe
//  cfg_addr_i      in   AW        staging index; addr k lands in DSP k
//  cfg_dat_i       in   DAT_BITS  coefficient word
//  cfg_ready_o     out  1         1 = staging writes accepted
//  cfg_err_o       out  1         sticky: a write arrived with cfg_ready_o=0
//  commit_i        in   1         single-cycle load request
//  busy_o          out  1         load sequence in progress or pending
//  done_o          out  1         1-cycle pulse after update issued
//  coeff_dat_o     out  DAT_BITS  to IIR coeff_dat_i
//  coeff_wr_o      out  1         to IIR coeff_wr_i (B1 shift enable)
//  coeff_update_o  out  1         to IIR coeff_update_i (B2 load)
// BEHAVIOUR
//  Reset: all outputs 0 except cfg_ready_o=1; staging regs=0; FSM=IDLE; pending=0.
//  All outputs registered. coeff_dat_o = 0 whenever coeff_wr_o = 0.
//  FSM: IDLE -> SHIFT (NCOEFF cycles) -> UPDATE (1 cycle) -> DONE (1 cycle) -> IDLE.
//  - IDLE: commit_i=1 or pending=1 -> SHIFT, idx=NCOEFF-1; pending cleared.
//  - SHIFT: coeff_wr_o=1, coeff_dat_o=stage[idx]; idx decrements; at idx=0 -> UPDATE.
//    Descending order is mandatory: first word shifted ends in last DSP.
//  - UPDATE: coeff_update_o=1, coeff_wr_o=0.
//  - DONE: done_o=1; -> SHIFT if pending, else IDLE.
//  Latency: commit seen at edge 0 -> coeff_wr_o high edges 1..NCOEFF -> coeff_update_o at
//   NCOEFF+1 -> done_o at NCOEFF+2. coeff_wr_o strictly contiguous, never with update.
//  busy_o = (state!=IDLE) | pending; cfg_ready_o = (state!=SHIFT).
//  Writes: accepted when cfg_ready_o=1 (IDLE, UPDATE, DONE); addr>=NCOEFF ignored and sets
//   cfg_err_o. Write with ready=0 dropped, sets cfg_err_o. cfg_err_o clears on commit
//   accepted from IDLE.
//  Simultaneous cfg_wr_i + commit_i in IDLE: write lands first; the new value is shifted.
//  commit_i in SHIFT/UPDATE/DONE: sets pending (multiple collapse to one); no abort.
//  Reset mid-SHIFT: outputs drop immediately; no update pulse issued, so IIR B2 (active)
//   coefficients are unchanged; B1 partial contents are overwritten by next full load.
// STRUCTURE
//  Shared header biquad_defs.vh: NCOEFF=4, DAT_BITS=18, coefficient Q formats
//   (A port Q17.13, C/P Q21.27), FSM state encodings.
//  Single module; staging file is NCOEFF x DAT_BITS flops (no RAM). No sub-module needed.
// TESTING
//  1 Write 0x00011,0x00022,0x00033,0x00044 to addr 0..3, commit -> coeff_dat_o seq
//    0x00044,0x00033,0x00022,0x00011 on 4 consecutive wr cycles, update next cycle,
//    done one after; behavioural 4-stage B1/B2 model holds DSP0..3=0x11,0x22,0x33,0x44.
//  2 Commit at cycle 2 of SHIFT -> busy_o stays high; second full sequence starts the cycle
//    after done_o; exactly 2 done_o pulses and 2 update pulses total.
//  3 cfg_wr_i during SHIFT (addr 1, 0x3FFFF) -> dropped, cfg_err_o=1, shifted data
//    unaffected; next IDLE commit clears cfg_err_o.
//  4 Same-cycle write addr 0=0x00055 + commit in IDLE -> last shifted word = 0x00055.
//  5 rst_n low at SHIFT cycle 3 -> all outputs 0 asynchronously, ready=1, no update;
//    model B2 unchanged; after reset a fresh commit loads all-zero staging.
//  6 Randomised writes/commits 10k cycles vs model -> wr/update never overlap; B2 always
//    equals staging snapshot at commit.

Source files
------------

// File: rtl/biquad_coeff_loader_pkg.sv
// biquad_coeff_loader_pkg: shared sizes and FSM encoding for the biquad coefficient loader
package biquad_coeff_loader_pkg;
  localparam int DEF_NCOEFF = 4;
  localparam int DEF_DAT_BITS = 18;
  localparam int DEF_AW = 2;
  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE, DONE} state_t;
endpackage

// File: rtl/biquad_coeff_loader.sv
// biquad_coeff_loader: stages host coefficients, shifts them down the DSP B cascade, then pulses update
module biquad_coeff_loader
  import biquad_coeff_loader_pkg::*;
#(
  parameter int NCOEFF = DEF_NCOEFF,
  parameter int DAT_BITS = DEF_DAT_BITS,
  parameter int AW = DEF_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_wr_i,
  input  logic [AW-1:0]       cfg_addr_i,
  input  logic [DAT_BITS-1:0] cfg_dat_i,
  output logic                cfg_ready_o,
  output logic                cfg_err_o,
  input  logic                commit_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [DAT_BITS-1:0] coeff_dat_o,
  output logic                coeff_wr_o,
  output logic                coeff_update_o
);
  state_t state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic pending, pending_nx, err_nx, start, idle, wr_ok, bad;
  logic [DAT_BITS-1:0] stage [NCOEFF];
  assign idle = state == IDLE;
  assign cfg_ready_o = state != SHIFT;
  assign busy_o = !idle || pending;
  assign wr_ok = cfg_wr_i && cfg_ready_o && (int'(cfg_addr_i) < NCOEFF);
  assign bad = cfg_wr_i && !wr_ok;
  assign start = (idle && (commit_i || pending)) || (state == DONE && pending);
  always_comb begin
    state_nx = start ? SHIFT :
               state == SHIFT ? (idx == '0 ? UPDATE : SHIFT) :
               state == UPDATE ? DONE : IDLE;
    idx_nx = start ? AW'(NCOEFF - 1) : idx - AW'(state == SHIFT);
    pending_nx = !start && (pending || commit_i);
    err_nx = (cfg_err_o && !(idle && commit_i)) || bad;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      pending <= 1'b0;
      cfg_err_o <= 1'b0;
      coeff_dat_o <= '0;
      coeff_wr_o <= 1'b0;
      coeff_update_o <= 1'b0;
      done_o <= 1'b0;
      for (int i = 0; i < NCOEFF; i++) stage[i] <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      pending <= pending_nx;
      cfg_err_o <= err_nx;
      coeff_wr_o <= state == SHIFT;
      coeff_dat_o <= state == SHIFT ? stage[idx] : '0;
      coeff_update_o <= state == UPDATE;
      done_o <= state == DONE;
      if (wr_ok) stage[cfg_addr_i] <= cfg_dat_i;
    end
endmodule

// File: tb/tb_biquad_coeff_loader.sv
// tb_biquad_coeff_loader: scoreboard bench with a cascade-level reference model of the IIR B1/B2 registers
module tb_biquad_coeff_loader;
  import biquad_coeff_loader_pkg::*;
  localparam int N = 4, W = 18, AW = 2;
  logic clk = 0, rst_n = 0, cfg_wr_i = 0, commit_i = 0;
  logic [AW-1:0] cfg_addr_i = '0;
  logic [W-1:0] cfg_dat_i = '0;
  logic cfg_ready_o, cfg_err_o, busy_o, done_o, coeff_wr_o, coeff_update_o;
  logic [W-1:0] coeff_dat_o;
  always #5 clk = ~clk;
  biquad_coeff_loader #(.NCOEFF(N), .DAT_BITS(W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr_i(cfg_wr_i), .cfg_addr_i(cfg_addr_i), .cfg_dat_i(cfg_dat_i),
    .cfg_ready_o(cfg_ready_o), .cfg_err_o(cfg_err_o), .commit_i(commit_i), .busy_o(busy_o),
    .done_o(done_o), .coeff_dat_o(coeff_dat_o), .coeff_wr_o(coeff_wr_o), .coeff_update_o(coeff_update_o));
  int n_cmp = 0, n_bad = 0, n_done = 0, n_upd = 0, e = 0, s = -100;
  bit pend = 0, m_err = 0;
  logic [W-1:0] m_stage [N];
  logic [W-1:0] b1 [N];
  logic [W-1:0] b2 [N];
  logic [W-1:0] q_dat [$];
  logic [N*W-1:0] q_snap [$];
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, e);
    end
  endtask
  task automatic model(input bit wr, input int addr, input logic [W-1:0] dat, input bit cm);
    bit in_seq, shifting, go;
    logic [N*W-1:0] snap;
    in_seq = e >= s + 1 && e <= s + N + 2;
    shifting = e >= s + 1 && e <= s + N;
    go = 0;
    if (cm && !in_seq) m_err = 0;
    if (wr) begin
      if (shifting || addr >= N) m_err = 1;
      else m_stage[addr] = dat;
    end
    if (!in_seq) go = cm || pend;
    else if (e == s + N + 2) begin
      go = pend;
      if (!pend && cm) pend = 1;
    end else if (cm) pend = 1;
    if (go) begin
      s = e;
      pend = 0;
      for (int k = N - 1; k >= 0; k--) q_dat.push_back(m_stage[k]);
      for (int k = 0; k < N; k++) snap[k*W +: W] = m_stage[k];
      q_snap.push_back(snap);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < N; k++) m_stage[k] = '0;
    s = -100;
    pend = 0;
    m_err = 0;
    q_dat.delete();
    q_snap.delete();
  endtask
  task automatic cyc(input bit wr, input int addr, input logic [W-1:0] dat, input bit cm);
    cfg_wr_i = wr;
    cfg_addr_i = AW'(addr);
    cfg_dat_i = dat;
    commit_i = cm;
    @(posedge clk);
    e++;
    model(wr, addr, dat, cm);
    #1;
    chk("busy", busy_o, (e >= s && e <= s + N + 1) || pend);
    chk("ready", cfg_ready_o, !(e >= s && e <= s + N - 1));
    chk("err", cfg_err_o, m_err);
    cfg_wr_i = 0;
    commit_i = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, '0, 0);
  endtask
  task automatic chk_reset_outs();
    chk("rst_outs", {coeff_wr_o, coeff_update_o, done_o, busy_o, cfg_err_o, coeff_dat_o}, '0);
    chk("rst_ready", cfg_ready_o, 1);
  endtask
  initial begin : monitor
    int run;
    bit prev_upd;
    logic [N*W-1:0] pk;
    run = 0;
    prev_upd = 0;
    for (int k = 0; k < N; k++) begin b1[k] = '0; b2[k] = '0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
        prev_upd = 0;
      end else begin
        chk("wr_upd_overlap", coeff_wr_o & coeff_update_o, 0);
        if (coeff_wr_o) begin
          if (q_dat.size() == 0) chk("wr_unexpected", coeff_wr_o, 0);
          else chk("shift_dat", coeff_dat_o, q_dat.pop_front());
          for (int k = N - 1; k > 0; k--) b1[k] = b1[k-1];
          b1[0] = coeff_dat_o;
          run++;
        end else begin
          chk("dat_idle_zero", coeff_dat_o, 0);
          if (run > 0) begin
            chk("wr_run_len", run, N);
            chk("upd_after_run", coeff_update_o, 1);
            run = 0;
          end else chk("upd_without_run", coeff_update_o, 0);
        end
        if (coeff_update_o) begin
          n_upd++;
          for (int k = 0; k < N; k++) begin b2[k] = b1[k]; pk[k*W +: W] = b1[k]; end
          if (q_snap.size() == 0) chk("upd_unexpected", coeff_update_o, 0);
          else chk("b2_snapshot", pk, q_snap.pop_front());
        end
        chk("done_after_upd", done_o, prev_upd);
        if (done_o) n_done++;
        prev_upd = coeff_update_o;
      end
    end
  end
  initial begin : stim
    int d0, u0;
    logic [W-1:0] saved [N];
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs();
    rst_n = 1;
    for (int k = 0; k < N; k++) cyc(1, k, W'((k + 1) * 'h11), 0);
    cyc(0, 0, '0, 1);
    chk("t1_lat0_wr", coeff_wr_o, 0);
    for (int k = 0; k < N; k++) begin
      cyc(0, 0, '0, 0);
      chk("t1_wr_hi", coeff_wr_o, 1);
    end
    cyc(0, 0, '0, 0);
    chk("t1_upd", coeff_update_o, 1);
    cyc(0, 0, '0, 0);
    chk("t1_done", done_o, 1);
    idle(3);
    for (int k = 0; k < N; k++) chk("t1_b2", b2[k], W'((k + 1) * 'h11));
    d0 = n_done;
    u0 = n_upd;
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 1);
    chk("t2_busy", busy_o, 1);
    idle(20);
    chk("t2_done_cnt", n_done - d0, 2);
    chk("t2_upd_cnt", n_upd - u0, 2);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    cyc(1, 1, 18'h3FFFF, 0);
    chk("t3_err_set", cfg_err_o, 1);
    idle(10);
    chk("t3_b2_1", b2[1], 18'h22);
    cyc(0, 0, '0, 1);
    chk("t3_err_clr", cfg_err_o, 0);
    idle(10);
    cyc(1, 0, 18'h55, 1);
    idle(10);
    chk("t4_b2_0", b2[0], 18'h55);
    for (int k = 0; k < N; k++) cyc(1, k, W'('h100 + k), 0);
    idle(2);
    for (int k = 0; k < N; k++) saved[k] = b2[k];
    u0 = n_upd;
    cyc(0, 0, '0, 1);
    idle(3);
    rst_n = 0;
    #1;
    chk_reset_outs();
    model_reset();
    repeat (2) begin @(posedge clk); e++; end
    #1;
    rst_n = 1;
    idle(3);
    chk("t5_no_upd", n_upd - u0, 0);
    for (int k = 0; k < N; k++) chk("t5_b2_kept", b2[k], saved[k]);
    cyc(0, 0, '0, 1);
    idle(10);
    for (int k = 0; k < N; k++) chk("t5_b2_zero", b2[k], 0);
    repeat (10000) cyc($urandom % 100 < 30, $urandom_range(0, N - 1), W'($urandom), $urandom % 100 < 4);
    idle(30);
    chk("drain_dat", q_dat.size(), 0);
    chk("drain_snap", q_snap.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
